// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the 65HE06 instruction prefetch path.
package fetch_pkg;

  localparam int WORD_W = 16;
  localparam int INC_1W = 2;   // byte step for one 16-bit word
  localparam int INC_2W = 4;   // byte step for two 16-bit words

  typedef logic [WORD_W-1:0] word_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Circular buffer of 16-bit instruction words: one push, zero/one/two pops per cycle,
// exposing the head word, the word behind it and the fill count.
module word_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  word_t            push_data,
  input  logic             pop,
  input  logic             pop2,
  output word_t            head,
  output word_t            head_next,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [1:0]       pop_n;
  word_t            store [DEPTH];

  assign pop_n      = pop ? (pop2 ? 2'd2 : 2'd1) : 2'd0;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // NOTE: sequential state is updated with <= only, so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  // NOTE: storage is deliberately not reset; the outputs below are masked by count instead.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  assign head      = (count != '0)         ? store[rd_ptr]     : '0;
  assign head_next = (count >= CNT_W'(2))  ? store[rd_ptr_nxt] : '0;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: streams words from memory into a small queue ahead of the
// decoder, tracks in-flight requests and discards stale responses after a redirect.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  word_t             mem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              d_valid,
  output logic [ADDR_W-1:0] d_pc,
  output word_t             d_opc,
  output word_t             d_arg,
  input  logic              d_take,
  input  logic              d_len2
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:1], 1'b0};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] redir_target;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  out_next;
  logic [OUT_W-1:0]  kill;
  logic [CNT_W-1:0]  count;
  logic [SUM_W-1:0]  inflight;
  logic              accept;
  logic              push;
  logic              take;
  logic              redir_lsb_unused;

  assign redir_lsb_unused = redir_pc[0];
  assign redir_target     = {redir_pc[ADDR_W-1:1], 1'b0};

  // Words already queued plus words still coming back that will actually be kept.
  assign inflight = SUM_W'(count) + SUM_W'(outstanding) - SUM_W'(kill);

  assign mem_req  = ~rst & ~redir_valid
                  & (inflight < SUM_W'(DEPTH))
                  & (outstanding < OUT_W'(MAX_OUT));
  assign mem_addr = fetch_pc;
  assign accept   = mem_req & mem_ready;

  assign push     = mem_rvalid & ~redir_valid & (kill == '0);
  assign d_valid  = ~rst & ~redir_valid & (count >= CNT_W'(2));
  assign take     = d_take & d_valid;
  assign out_next = outstanding + OUT_W'(accept) - OUT_W'(mem_rvalid);
  assign d_pc     = head_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= START_PC;
      head_pc     <= START_PC;
      outstanding <= '0;
      kill        <= '0;
    end else begin
      outstanding <= out_next;
      if (redir_valid) begin
        // Everything still pending after this edge belongs to the old stream.
        fetch_pc <= redir_target;
        head_pc  <= redir_target;
        kill     <= out_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(INC_1W);
        if (take)   head_pc  <= head_pc + (d_len2 ? ADDR_W'(INC_2W) : ADDR_W'(INC_1W));
        if (mem_rvalid && (kill != '0)) kill <= kill - OUT_W'(1);
      end
    end
  end

  word_fifo #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redir_valid),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (take),
    .pop2      (d_len2),
    .head      (d_opc),
    .head_next (d_arg),
    .count     (count)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a variable-latency in-order memory model plus
// hand-sequenced scenarios for streaming, back-pressure, redirects, wrap and reset.
module tb_prefetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  word_t       mem_rdata;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        d_valid;
  logic [15:0] d_pc;
  word_t       d_opc;
  word_t       d_arg;
  logic        d_take;
  logic        d_len2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] acc_log[$];

  always #5 clk = ~clk;

  prefetch_unit #(
    .ADDR_W   (16),
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (16'h0200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .d_valid     (d_valid),
    .d_pc        (d_pc),
    .d_opc       (d_opc),
    .d_arg       (d_arg),
    .d_take      (d_take),
    .d_len2      (d_len2)
  );

  function automatic word_t word_at(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int g = 0;
    while (!d_valid && g < 50) begin
      tick();
      g++;
    end
    check(tag, {31'b0, d_valid}, 32'd1);
  endtask

  task automatic log_at(input string tag, input int idx, input logic [15:0] exp);
    if (idx < acc_log.size()) check(tag, {16'b0, acc_log[idx]}, {16'b0, exp});
    else check({tag, "_missing"}, acc_log.size(), idx + 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: decisions for the upcoming edge are made on the falling edge.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word_at(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (mem_req && mem_ready) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + 1 + lat);
        acc_log.push_back(mem_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    bit found;

    rst = 1'b1; mem_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    d_take = 1'b0; d_len2 = 1'b0;
    repeat (2) tick();

    check("rst_mem_req",  {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0200);
    check("rst_d_valid",  {31'b0, d_valid}, 32'd0);
    check("rst_d_pc",     d_pc, 32'h0200);
    check("rst_d_opc",    d_opc, 32'h0);
    check("rst_d_arg",    d_arg, 32'h0);

    // Stream at latency 1.
    rst = 1'b0;
    #1;
    check("first_req", {31'b0, mem_req}, 32'd1);
    tick(); tick();
    check("dv_early", {31'b0, d_valid}, 32'd0);
    tick();
    check("dv_rise",  {31'b0, d_valid}, 32'd1);
    check("s_d_pc",   d_pc, 32'h0200);
    check("s_d_opc",  d_opc, word_at(16'h0200));
    check("s_d_arg",  d_arg, word_at(16'h0202));

    // Back-pressure: queue of 4 must stop fetching.
    repeat (10) tick();
    check("bp_reqs",  acc_log.size(), 32'd4);
    log_at("bp_last", 3, 16'h0206);
    check("bp_req",   {31'b0, mem_req}, 32'd0);
    check("bp_opc",   d_opc, word_at(16'h0200));

    d_take = 1'b1; d_len2 = 1'b1;
    tick();
    d_take = 1'b0;
    check("len2_pc",  d_pc, 32'h0204);
    check("len2_opc", d_opc, word_at(16'h0204));
    check("len2_arg", d_arg, word_at(16'h0206));
    repeat (6) tick();
    check("len2_refill", acc_log.size(), 32'd6);

    d_take = 1'b1; d_len2 = 1'b0;
    tick();
    d_take = 1'b0;
    check("len1_pc",  d_pc, 32'h0206);
    check("len1_opc", d_opc, word_at(16'h0206));
    check("len1_arg", d_arg, word_at(16'h0208));
    repeat (6) tick();
    check("len1_single", acc_log.size(), 32'd7);
    log_at("len1_addr", 6, 16'h020C);

    // Build two outstanding requests at latency 3, then redirect over them.
    lat = 3;
    redir_valid = 1'b1; redir_pc = 16'h1000;
    tick();
    redir_valid = 1'b0;
    base = acc_log.size();
    g = 0;
    while (acc_log.size() < base + 2 && g < 20) begin
      tick();
      g++;
    end
    check("two_out", acc_log.size(), base + 2);

    redir_valid = 1'b1; redir_pc = 16'h1235;
    #1;
    check("rd_cycle_dv",  {31'b0, d_valid}, 32'd0);
    check("rd_cycle_req", {31'b0, mem_req}, 32'd0);
    tick();
    redir_valid = 1'b0;
    check("rd_d_pc",     d_pc, 32'h1234);
    check("rd_mem_addr", mem_addr, 32'h1234);
    base = acc_log.size();
    wait_valid("rd_dv");
    log_at("rd_first_req", base, 16'h1234);
    check("rd_opc", d_opc, word_at(16'h1234));
    check("rd_arg", d_arg, word_at(16'h1236));

    // Redirect in the same cycle as a response and a take.
    found = 1'b0;
    g = 0;
    while (!found && g < 40) begin
      if (d_valid && pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
        found = 1'b1;
      end else begin
        d_take = d_valid; d_len2 = 1'b0;
        tick();
        d_take = 1'b0;
        g++;
      end
    end
    check("co_found", {31'b0, found}, 32'd1);
    redir_valid = 1'b1; redir_pc = 16'h2000; d_take = 1'b1; d_len2 = 1'b1;
    tick();
    redir_valid = 1'b0; d_take = 1'b0;
    check("co_d_pc", d_pc, 32'h2000);
    check("co_dv",   {31'b0, d_valid}, 32'd0);
    wait_valid("co_dv_back");
    check("co_pc2",  d_pc, 32'h2000);
    check("co_opc",  d_opc, word_at(16'h2000));
    check("co_arg",  d_arg, word_at(16'h2002));

    // Address wrap at the top of the 16-bit space.
    lat = 1;
    redir_valid = 1'b1; redir_pc = 16'hFFFC;
    tick();
    redir_valid = 1'b0;
    base = acc_log.size();
    wait_valid("wr_dv");
    repeat (6) tick();
    log_at("wr_a0", base,     16'hFFFC);
    log_at("wr_a1", base + 1, 16'hFFFE);
    log_at("wr_a2", base + 2, 16'h0000);
    check("wr_pc0", d_pc, 32'hFFFC);
    d_take = 1'b1; d_len2 = 1'b0;
    tick();
    check("wr_pc1", d_pc, 32'hFFFE);
    d_len2 = 1'b1;
    tick();
    d_take = 1'b0;
    check("wr_pc2",  d_pc, 32'h0002);
    check("wr_opc2", d_opc, word_at(16'h0002));

    // Reset in the middle of a stream.
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("mr_req_now", {31'b0, mem_req}, 32'd0);
    check("mr_dv_now",  {31'b0, d_valid}, 32'd0);
    tick();
    check("mr_req",  {31'b0, mem_req}, 32'd0);
    check("mr_dv",   {31'b0, d_valid}, 32'd0);
    check("mr_pc",   d_pc, 32'h0200);
    check("mr_addr", mem_addr, 32'h0200);
    check("mr_opc",  d_opc, 32'h0);
    rst = 1'b0;
    base = acc_log.size();
    tick(); tick();
    check("mr_dv_early", {31'b0, d_valid}, 32'd0);
    tick();
    check("mr_dv_rise", {31'b0, d_valid}, 32'd1);
    log_at("mr_first_req", base, 16'h0200);
    check("mr_opc2", d_opc, word_at(16'h0200));
    check("mr_arg2", d_arg, word_at(16'h0202));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
